vx_commit_arbiter: RTL and testbench

VX_COMMIT_ARBITER -- requirements
Module: vx_commit_arbiter

---
 rtl/vx_commit_arbiter.sv | 152 +++++++++++++++
 tb/tb_vx_commit_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_commit_arbiter.sv
// Commit arbiter: picks one commit beat per cycle from NUM_REQS sources and
// registers it toward the register-file writeback and retire counter.
module vx_commit_arbiter #(
  parameter int CORE_ID     = 0,
  parameter int NUM_REQS    = 4,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5,
  parameter int UUID_BITS   = 44
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQS-1:0]                 cmt_valid_in,
  output logic [NUM_REQS-1:0]                 cmt_ready_in,
  input  logic [NUM_REQS*UUID_BITS-1:0]       cmt_uuid_in,
  input  logic [NUM_REQS*NW_BITS-1:0]         cmt_wid_in,
  input  logic [NUM_REQS*NUM_THREADS-1:0]     cmt_tmask_in,
  input  logic [NUM_REQS*32-1:0]              cmt_PC_in,
  input  logic [NUM_REQS*NR_BITS-1:0]         cmt_rd_in,
  input  logic [NUM_REQS-1:0]                 cmt_wb_in,
  input  logic [NUM_REQS-1:0]                 cmt_eop_in,
  input  logic [NUM_REQS*NUM_THREADS*32-1:0]  cmt_data_in,
  output logic                                wb_valid,
  output logic [UUID_BITS-1:0]                wb_uuid,
  output logic [NW_BITS-1:0]                  wb_wid,
  output logic [NUM_THREADS-1:0]              wb_tmask,
  output logic [31:0]                         wb_PC,
  output logic [NR_BITS-1:0]                  wb_rd,
  output logic [NUM_THREADS*32-1:0]           wb_data,
  output logic                                cmt_fire,
  output logic                                cmt_eop,
  output logic [$clog2(NUM_REQS)-1:0]         cmt_src,
  output logic [63:0]                         retire_count,
  output logic                                dbg_locked,
  output logic [7:0]                          dbg_core_id
);
  localparam int SRC_W = $clog2(NUM_REQS);
  localparam int SUM_W = SRC_W + 1;
  localparam int DW    = NUM_THREADS * 32;

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  state_t             state;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   lock_idx;
  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  logic [SUM_W-1:0]   sum;
  logic [SUM_W-1:0]   next_sum;
  logic [SRC_W-1:0]   next_ptr;
  logic [UUID_BITS-1:0]   sel_uuid;
  logic [NW_BITS-1:0]     sel_wid;
  logic [NUM_THREADS-1:0] sel_tmask;
  logic [31:0]            sel_pc;
  logic [NR_BITS-1:0]     sel_rd;
  logic [DW-1:0]          sel_data;

  assign dbg_locked  = (state == ST_LOCKED);
  assign dbg_core_id = 8'(CORE_ID);

  // Multi-beat instructions hold the grant on their source until the eop beat.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    if (state == ST_LOCKED) begin
      grant_found = cmt_valid_in[lock_idx];
      grant_idx   = lock_idx;
    end else begin
      for (int k = 0; k < NUM_REQS; k++) begin
        sum = {1'b0, rr_ptr} + SUM_W'(k);
        if (sum >= SUM_W'(NUM_REQS)) sum = sum - SUM_W'(NUM_REQS);
        if (!grant_found && cmt_valid_in[sum[SRC_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = sum[SRC_W-1:0];
        end
      end
    end
  end

  // Handshake: a beat transfers when cmt_valid_in[i] and cmt_ready_in[i] are
  // both high at a rising edge; ready never depends on anything downstream.
  always_comb begin
    cmt_ready_in = '0;
    if (grant_found && !reset) cmt_ready_in[grant_idx] = 1'b1;
  end

  always_comb begin
    next_sum = {1'b0, grant_idx} + SUM_W'(1);
    next_ptr = (next_sum == SUM_W'(NUM_REQS)) ? '0 : next_sum[SRC_W-1:0];
  end

  always_comb begin
    sel_uuid  = '0;
    sel_wid   = '0;
    sel_tmask = '0;
    sel_pc    = '0;
    sel_rd    = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_uuid  = cmt_uuid_in[i*UUID_BITS +: UUID_BITS];
        sel_wid   = cmt_wid_in[i*NW_BITS +: NW_BITS];
        sel_tmask = cmt_tmask_in[i*NUM_THREADS +: NUM_THREADS];
        sel_pc    = cmt_PC_in[i*32 +: 32];
        sel_rd    = cmt_rd_in[i*NR_BITS +: NR_BITS];
        sel_data  = cmt_data_in[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_UNLOCKED;
      rr_ptr       <= '0;
      lock_idx     <= '0;
      cmt_fire     <= 1'b0;
      cmt_eop      <= 1'b0;
      wb_valid     <= 1'b0;
      cmt_src      <= '0;
      wb_uuid      <= '0;
      wb_wid       <= '0;
      wb_tmask     <= '0;
      wb_PC        <= '0;
      wb_rd        <= '0;
      wb_data      <= '0;
      retire_count <= '0;
    end else begin
      cmt_fire <= grant_found;
      cmt_eop  <= grant_found & cmt_eop_in[grant_idx];
      wb_valid <= grant_found & cmt_wb_in[grant_idx];
      if (grant_found) begin
        cmt_src  <= grant_idx;
        wb_uuid  <= sel_uuid;
        wb_wid   <= sel_wid;
        wb_tmask <= sel_tmask;
        wb_PC    <= sel_pc;
        wb_rd    <= sel_rd;
        wb_data  <= sel_data;
        if (cmt_eop_in[grant_idx]) begin
          state        <= ST_UNLOCKED;
          rr_ptr       <= next_ptr;
          retire_count <= retire_count + 64'd1;
        end else begin
          state    <= ST_LOCKED;
          lock_idx <= grant_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Bench for vx_commit_arbiter: directed scenarios plus a randomized run
// against a small round-robin/lock reference model, with a beat scoreboard.
module tb_vx_commit_arbiter;
  localparam int N  = 4;
  localparam int T  = 4;
  localparam int NW = 2;
  localparam int NR = 5;
  localparam int UB = 44;
  localparam int W  = 2 + 1 + 1 + NR + T + NW + 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      cmt_valid_in = '0;
  logic [N-1:0]      cmt_ready_in;
  logic [N*UB-1:0]   cmt_uuid_in = '0;
  logic [N*NW-1:0]   cmt_wid_in = '0;
  logic [N*T-1:0]    cmt_tmask_in = '0;
  logic [N*32-1:0]   cmt_PC_in = '0;
  logic [N*NR-1:0]   cmt_rd_in = '0;
  logic [N-1:0]      cmt_wb_in = '0;
  logic [N-1:0]      cmt_eop_in = '0;
  logic [N*T*32-1:0] cmt_data_in = '0;
  logic              wb_valid;
  logic [UB-1:0]     wb_uuid;
  logic [NW-1:0]     wb_wid;
  logic [T-1:0]      wb_tmask;
  logic [31:0]       wb_PC;
  logic [NR-1:0]     wb_rd;
  logic [T*32-1:0]   wb_data;
  logic              cmt_fire;
  logic              cmt_eop;
  logic [1:0]        cmt_src;
  logic [63:0]       retire_count;
  logic              dbg_locked;
  logic [7:0]        dbg_core_id;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [63:0]  exp_retire = '0;
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_got;

  vx_commit_arbiter #(.CORE_ID(0), .NUM_REQS(N), .NUM_THREADS(T), .NW_BITS(NW),
                      .NR_BITS(NR), .UUID_BITS(UB)) dut (
    .clk(clk), .reset(reset),
    .cmt_valid_in(cmt_valid_in), .cmt_ready_in(cmt_ready_in),
    .cmt_uuid_in(cmt_uuid_in), .cmt_wid_in(cmt_wid_in), .cmt_tmask_in(cmt_tmask_in),
    .cmt_PC_in(cmt_PC_in), .cmt_rd_in(cmt_rd_in), .cmt_wb_in(cmt_wb_in),
    .cmt_eop_in(cmt_eop_in), .cmt_data_in(cmt_data_in),
    .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wid(wb_wid), .wb_tmask(wb_tmask),
    .wb_PC(wb_PC), .wb_rd(wb_rd), .wb_data(wb_data),
    .cmt_fire(cmt_fire), .cmt_eop(cmt_eop), .cmt_src(cmt_src),
    .retire_count(retire_count), .dbg_locked(dbg_locked), .dbg_core_id(dbg_core_id)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Driver tasks
  task automatic set_src(input int s, input logic v, input logic wb, input logic eop,
                         input logic [NR-1:0] rd, input logic [T-1:0] tm,
                         input logic [NW-1:0] wid, input logic [31:0] d);
    cmt_valid_in[s]          = v;
    cmt_wb_in[s]             = wb;
    cmt_eop_in[s]            = eop;
    cmt_rd_in[s*NR +: NR]    = rd;
    cmt_tmask_in[s*T +: T]   = tm;
    cmt_wid_in[s*NW +: NW]   = wid;
    cmt_PC_in[s*32 +: 32]    = d ^ 32'h0000_1000;
    cmt_uuid_in[s*UB +: UB]  = {12'(s), d};
    cmt_data_in[s*T*32 +: T*32] = {$urandom, $urandom, $urandom, d};
  endtask

  task automatic clear_all();
    cmt_valid_in = '0;
    cmt_eop_in   = '0;
    cmt_wb_in    = '0;
  endtask

  function automatic logic [W-1:0] mk_exp(input int s);
    return {2'(s), cmt_eop_in[s], cmt_wb_in[s], cmt_rd_in[s*NR +: NR],
            cmt_tmask_in[s*T +: T], cmt_wid_in[s*NW +: NW], cmt_data_in[s*T*32 +: 32]};
  endfunction

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic pulse_reset();
    reset = 1'b1;
    clear_all();
    exp_q.delete();
    exp_retire = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard: every retired beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!reset) begin
      if (cmt_fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got src=%0d rd=%0d, required no beat", cmt_src, wb_rd);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_got = {cmt_src, cmt_eop, wb_valid, wb_rd, wb_tmask, wb_wid, wb_data[31:0]};
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL beat_payload: got %h required %h", mon_got, mon_exp);
          end
          exp_retire = exp_retire + 64'(mon_exp[W-3]);
          checks++;
          if (retire_count !== exp_retire) begin
            errors++;
            $display("FAIL retire_count: got %0d required %0d", retire_count, exp_retire);
          end
        end
      end else begin
        checks++;
        if (wb_valid !== 1'b0 || cmt_eop !== 1'b0) begin
          errors++;
          $display("FAIL idle_strobes: got wb_valid=%b cmt_eop=%b required 0 0", wb_valid, cmt_eop);
        end
      end
    end
  end

  task automatic test_reset();
    cmt_valid_in = '1;
    repeat (2) @(negedge clk);
    checks++;
    if (cmt_ready_in !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b required 0000", cmt_ready_in);
    end
    checks++;
    if ({cmt_fire, wb_valid, cmt_eop, cmt_src, dbg_locked} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes: got %b required 000000",
                         {cmt_fire, wb_valid, cmt_eop, cmt_src, dbg_locked});
    end
    checks++;
    if (wb_rd !== '0 || wb_data !== '0 || wb_PC !== '0 || wb_uuid !== '0) begin
      errors++; $display("FAIL reset_payload: got rd=%0d data=%h required 0", wb_rd, wb_data);
    end
    checks++;
    if (retire_count !== 64'd0) begin
      errors++; $display("FAIL reset_retire: got %0d required 0", retire_count);
    end
    clear_all();
    reset = 1'b0;
  endtask

  task automatic test_single();
    set_src(0, 1'b1, 1'b1, 1'b1, 5'd5, 4'hF, 2'd1, 32'hDEAD_BEEF);
    cmt_PC_in[31:0] = 32'h0000_1000;
    #1;
    checks++;
    if (cmt_ready_in !== 4'b0001) begin
      errors++; $display("FAIL single_ready: got %b required 0001", cmt_ready_in);
    end
    exp_q.push_back(mk_exp(0));
    @(negedge clk);
    clear_all();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data[31:0] !== 32'hDEAD_BEEF || wb_PC !== 32'h1000) begin
      errors++; $display("FAIL single_wb: got v=%b rd=%0d d=%h pc=%h required 1 5 deadbeef 1000",
                         wb_valid, wb_rd, wb_data[31:0], wb_PC);
    end
    checks++;
    if (retire_count !== 64'd1) begin
      errors++; $display("FAIL single_retire: got %0d required 1", retire_count);
    end
    @(negedge clk);
    checks++;
    if (cmt_fire !== 1'b0 || wb_rd !== 5'd5) begin
      errors++; $display("FAIL single_pulse: got fire=%b rd=%0d required 0 5", cmt_fire, wb_rd);
    end
  endtask

  task automatic test_fairness();
    pulse_reset();
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < N; s++) set_src(s, 1'b1, 1'b1, 1'b1, 5'(10 + s), 4'hF, 2'(s), $urandom);
      #1;
      checks++;
      if (cmt_ready_in !== 4'(1 << (c % 4))) begin
        errors++; $display("FAIL fair_ready cycle %0d: got %b required %b", c, cmt_ready_in, 4'(1 << (c % 4)));
      end
      exp_q.push_back(mk_exp(c % 4));
      @(negedge clk);
    end
    clear_all();
    checks++;
    if (retire_count !== 64'd6) begin
      errors++; $display("FAIL fair_retire: got %0d required 6", retire_count);
    end
    @(negedge clk);
  endtask

  task automatic test_lock();
    logic [3:0] exp_ready;
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      set_src(2, 1'b1, 1'b1, 1'b1, 5'd22, 4'h3, 2'd2, $urandom);
      if (c < 3) set_src(1, 1'b1, 1'b1, (c == 2), 5'd11, 4'hC, 2'd1, $urandom);
      else cmt_valid_in[1] = 1'b0;
      exp_ready = (c < 3) ? 4'b0010 : 4'b0100;
      #1;
      checks++;
      if (cmt_ready_in !== exp_ready) begin
        errors++; $display("FAIL lock_ready cycle %0d: got %b required %b", c, cmt_ready_in, exp_ready);
      end
      exp_q.push_back(mk_exp((c < 3) ? 1 : 2));
      @(negedge clk);
      if (c == 3) clear_all();
      checks++;
      if (dbg_locked !== (c < 2)) begin
        errors++; $display("FAIL lock_state cycle %0d: got %b required %b", c, dbg_locked, (c < 2));
      end
    end
    checks++;
    if (retire_count !== 64'd2) begin
      errors++; $display("FAIL lock_retire: got %0d required 2", retire_count);
    end
    @(negedge clk);
  endtask

  task automatic test_lock_stall();
    set_src(1, 1'b1, 1'b1, 1'b0, 5'd3, 4'hF, 2'd1, $urandom);
    #1;
    checks++;
    if (cmt_ready_in !== 4'b0010) begin
      errors++; $display("FAIL stall_first_ready: got %b required 0010", cmt_ready_in);
    end
    exp_q.push_back(mk_exp(1));
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      cmt_valid_in[1] = 1'b0;
      set_src(0, 1'b1, 1'b1, 1'b1, 5'd9, 4'hF, 2'd0, $urandom);
      #1;
      checks++;
      if (cmt_ready_in !== 4'b0000) begin
        errors++; $display("FAIL stall_ready cycle %0d: got %b required 0000", c, cmt_ready_in);
      end
      @(negedge clk);
      checks++;
      if (cmt_fire !== 1'b0 || dbg_locked !== 1'b1) begin
        errors++; $display("FAIL stall_fire cycle %0d: got fire=%b locked=%b required 0 1", c, cmt_fire, dbg_locked);
      end
    end
    set_src(1, 1'b1, 1'b1, 1'b1, 5'd4, 4'hF, 2'd1, $urandom);
    #1;
    checks++;
    if (cmt_ready_in !== 4'b0010) begin
      errors++; $display("FAIL stall_release_ready: got %b required 0010", cmt_ready_in);
    end
    exp_q.push_back(mk_exp(1));
    @(negedge clk);
    cmt_valid_in[1] = 1'b0;
    #1;
    checks++;
    if (cmt_ready_in !== 4'b0001) begin
      errors++; $display("FAIL stall_after_ready: got %b required 0001", cmt_ready_in);
    end
    exp_q.push_back(mk_exp(0));
    @(negedge clk);
    clear_all();
    @(negedge clk);
  endtask

  task automatic test_no_write();
    set_src(3, 1'b1, 1'b0, 1'b1, 5'd17, 4'h5, 2'd3, $urandom);
    #1;
    checks++;
    if (cmt_ready_in !== 4'b1000) begin
      errors++; $display("FAIL nowb_ready: got %b required 1000", cmt_ready_in);
    end
    exp_q.push_back(mk_exp(3));
    @(negedge clk);
    clear_all();
    checks++;
    if ({cmt_fire, wb_valid, cmt_eop, cmt_src} !== 5'b10111 || retire_count !== 64'd5) begin
      errors++; $display("FAIL nowb_out: got fire=%b wb=%b eop=%b src=%0d cnt=%0d required 1 0 1 3 5",
                         cmt_fire, wb_valid, cmt_eop, cmt_src, retire_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_lock();
    set_src(2, 1'b1, 1'b1, 1'b0, 5'd21, 4'hF, 2'd2, $urandom);
    #1;
    checks++;
    if (cmt_ready_in !== 4'b0100) begin
      errors++; $display("FAIL rml_ready: got %b required 0100", cmt_ready_in);
    end
    exp_q.push_back(mk_exp(2));
    @(negedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    exp_retire = '0;
    #1;
    checks++;
    if ({cmt_fire, wb_valid, cmt_eop, cmt_src, dbg_locked} !== 6'b0 || wb_rd !== '0 || retire_count !== 64'd0) begin
      errors++; $display("FAIL rml_async: got fire=%b wb=%b src=%0d lk=%b rd=%0d cnt=%0d required all 0",
                         cmt_fire, wb_valid, cmt_src, dbg_locked, wb_rd, retire_count);
    end
    checks++;
    if (cmt_ready_in !== 4'b0000) begin
      errors++; $display("FAIL rml_ready_in_reset: got %b required 0000", cmt_ready_in);
    end
    @(negedge clk);
    reset = 1'b0;
    set_src(0, 1'b1, 1'b1, 1'b1, 5'd1, 4'hF, 2'd0, $urandom);
    set_src(2, 1'b1, 1'b1, 1'b1, 5'd2, 4'hF, 2'd2, $urandom);
    #1;
    checks++;
    if (cmt_ready_in !== 4'b0001) begin
      errors++; $display("FAIL rml_first_grant: got %b required 0001", cmt_ready_in);
    end
    exp_q.push_back(mk_exp(0));
    @(negedge clk);
    cmt_valid_in[0] = 1'b0;
    #1;
    exp_q.push_back(mk_exp(2));
    @(negedge clk);
    clear_all();
    checks++;
    if (retire_count !== 64'd2) begin
      errors++; $display("FAIL rml_retire: got %0d required 2", retire_count);
    end
    @(negedge clk);
  endtask

  // Back-to-back random traffic, including tmask=0 beats, checked against a reference model.
  task automatic test_random();
    int m_rr;
    int m_lock;
    int g;
    logic m_locked;
    logic [3:0] exp_ready;
    pulse_reset();
    m_rr = 0; m_lock = 0; m_locked = 1'b0;
    for (int c = 0; c < 80; c++) begin
      for (int s = 0; s < N; s++)
        set_src(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                5'($urandom), ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
                2'($urandom), $urandom);
      g = -1;
      if (m_locked) begin
        if (cmt_valid_in[m_lock]) g = m_lock;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && cmt_valid_in[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
      exp_ready = (g < 0) ? 4'b0000 : 4'(1 << g);
      #1;
      checks++;
      if (cmt_ready_in !== exp_ready) begin
        errors++; $display("FAIL rand_ready cycle %0d: got %b required %b", c, cmt_ready_in, exp_ready);
      end
      if (g >= 0) begin
        exp_q.push_back(mk_exp(g));
        if (cmt_eop_in[g]) begin
          m_locked = 1'b0;
          m_rr = (g + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_lock = g;
        end
      end
      @(negedge clk);
    end
    clear_all();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_drain: got %0d beats outstanding required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_lock_stall();
    test_no_write();
    test_reset_mid_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
